// File: rtl/gpio_mux_regfile.sv
// GPIO register file and pin multiplexer: DDR, open-drain, shadowed mux selects with commit, synchronised pin inputs.
// Optional per-pin input debounce enabled by defining GPIO_DEBOUNCE_EN.
module gpio_mux_regfile #(
  parameter int unsigned AddrWidth      = 16,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned NumPins        = 36,
  parameter int unsigned NumSrc         = 34,
  parameter int unsigned PortNumWidth   = 8,
  parameter int unsigned PinsPrReg      = 24,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic                   reg_clk,
  input  logic                   reset_reg,
  input  logic                   write_reg,
  input  logic                   read_reg,
  input  logic [AddrWidth-3:0]   busaddress,
  input  logic [BusWidth-1:0]    busdata_in,
  output logic [BusWidth-1:0]    busdata_out,
  output logic                   read_valid,
  input  logic [NumSrc-1:0]      out_data,
  output logic [NumSrc-1:0]      in_data,
  input  logic [NumPins-1:0]     pin_in,
  output logic [NumPins-1:0]     pin_out,
  output logic [NumPins-1:0]     pin_oe
);

  localparam int unsigned AW        = AddrWidth - 2;
  localparam int unsigned PW        = PortNumWidth;
  localparam int unsigned NDR       = (NumPins + PinsPrReg - 1) / PinsPrReg;
  localparam int unsigned SelPrWord = BusWidth / PortNumWidth;
  localparam int unsigned NMX       = (NumPins + SelPrWord - 1) / SelPrWord;
  localparam int unsigned LW        = SelPrWord * PW;
  localparam int unsigned DW        = NDR * PinsPrReg;
  localparam int unsigned MW        = NMX * LW;
  localparam int unsigned SW        = NumPins * PW;

  localparam logic [AW-1:0] DdrBase    = AW'(32'h1100 >> 2);
  localparam logic [AW-1:0] MuxBase    = AW'(32'h1120 >> 2);
  localparam logic [AW-1:0] PinBase    = AW'(32'h1200 >> 2);
  localparam logic [AW-1:0] OdBase     = AW'(32'h1300 >> 2);
  localparam logic [AW-1:0] CommitAddr = AW'(32'h1400 >> 2);

  logic                s1_wr;
  logic                s1_rd;
  logic [AW-1:0]       s1_addr;
  logic [BusWidth-1:0] s1_data;

  logic [NumPins-1:0]  ddr;
  logic [NumPins-1:0]  od;
  logic [SW-1:0]       shadow;
  logic [SW-1:0]       active;
  logic [NumPins-1:0]  sync1;
  logic [NumPins-1:0]  sync2;
  logic [NumPins-1:0]  pval;

  logic [DW-1:0]       ddr_pad, od_pad, pv_pad, ddr_nxt, od_nxt;
  logic [MW-1:0]       shd_pad, shd_nxt;
  logic [BusWidth-1:0] rdata;
  logic                commit;
  logic [NumPins-1:0]  src_v, drv_out, drv_oe;
  logic [NumSrc-1:0]   in_nxt;

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      s1_wr   <= 1'b0;
      s1_rd   <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_wr   <= write_reg;
      s1_rd   <= read_reg;
      s1_addr <= busaddress;
      s1_data <= busdata_in;
    end
  end

  // Registers are zero-padded to whole bus words so bits beyond NumPins read 0 and drop writes.
  assign ddr_pad = DW'(ddr);
  assign od_pad  = DW'(od);
  assign pv_pad  = DW'(pval);
  assign shd_pad = MW'(shadow);

  always_comb begin
    rdata   = '0;
    ddr_nxt = ddr_pad;
    od_nxt  = od_pad;
    shd_nxt = shd_pad;
    commit  = 1'b0;
    for (int unsigned k = 0; k < NDR; k++) begin
      if (s1_addr == DdrBase + AW'(k)) begin
        rdata = BusWidth'(ddr_pad[k*PinsPrReg +: PinsPrReg]);
        if (s1_wr) ddr_nxt[k*PinsPrReg +: PinsPrReg] = s1_data[PinsPrReg-1:0];
      end
      if (s1_addr == OdBase + AW'(k)) begin
        rdata = BusWidth'(od_pad[k*PinsPrReg +: PinsPrReg]);
        if (s1_wr) od_nxt[k*PinsPrReg +: PinsPrReg] = s1_data[PinsPrReg-1:0];
      end
      if (s1_addr == PinBase + AW'(k)) begin
        rdata = BusWidth'(pv_pad[k*PinsPrReg +: PinsPrReg]);
      end
    end
    for (int unsigned m = 0; m < NMX; m++) begin
      if (s1_addr == MuxBase + AW'(m)) begin
        rdata = BusWidth'(shd_pad[m*LW +: LW]);
        if (s1_wr) shd_nxt[m*LW +: LW] = s1_data[LW-1:0];
      end
    end
    if (s1_addr == CommitAddr) commit = s1_wr;
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      ddr         <= '0;
      od          <= '0;
      busdata_out <= '0;
      read_valid  <= 1'b0;
      for (int unsigned i = 0; i < NumPins; i++) begin
        shadow[i*PW +: PW] <= PW'(i);
        active[i*PW +: PW] <= PW'(i);
      end
    end else begin
      ddr         <= ddr_nxt[NumPins-1:0];
      od          <= od_nxt[NumPins-1:0];
      shadow      <= shd_nxt[SW-1:0];
      busdata_out <= s1_rd ? rdata : '0;
      read_valid  <= s1_rd;
      if (commit) active <= shadow;
    end
  end

  always_comb begin
    src_v   = '0;
    drv_out = '0;
    drv_oe  = '0;
    for (int unsigned i = 0; i < NumPins; i++) begin
      for (int unsigned j = 0; j < NumSrc; j++) begin
        if (active[i*PW +: PW] == PW'(j)) src_v[i] = out_data[j];
      end
      drv_out[i] = od[i] ? 1'b0 : src_v[i];
      drv_oe[i]  = od[i] ? (ddr[i] & ~src_v[i]) : ddr[i];
    end
  end

  // Descending scan so the lowest-index matching input pin wins each source.
  always_comb begin
    in_nxt = '0;
    for (int unsigned j = 0; j < NumSrc; j++) begin
      for (int unsigned i = NumPins; i > 0; i--) begin
        if (!ddr[i-1] && active[(i-1)*PW +: PW] == PW'(j)) in_nxt[j] = pval[i-1];
      end
    end
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      sync1   <= '0;
      sync2   <= '0;
      pin_out <= '0;
      pin_oe  <= '0;
      in_data <= '0;
    end else begin
      sync1   <= pin_in;
      sync2   <= sync1;
      pin_out <= drv_out;
      pin_oe  <= drv_oe;
      in_data <= in_nxt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DebounceCycles + 1);

  logic [CW-1:0]      db_cnt [NumPins];
  logic [NumPins-1:0] db_val;

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      db_val <= '0;
      for (int unsigned i = 0; i < NumPins; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumPins; i++) begin
        if (sync2[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DebounceCycles - 1)) begin
          db_val[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign pval = db_val;
`else
  assign pval = sync2;
`endif

endmodule
